qos_burst_arbiter: RTL and testbench

- Locking, QoS-aware round-robin arbiter for the interconnect.
- Grants one of `NUM_REQ` requesters for a multi-beat burst and holds the grant until the burst ends, is aborted, or hits `MAX_BURST`.
- Selection order: starved requesters first, then the high-priority class, then the low-priority class.
- Sits between the CPU/GPU request ports and the shared memory channel; requester 0 is the CPU, the rest are GPU units.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_find_first.sv | 34 +++
 rtl/qos_burst_arbiter.sv | 168 ++++++++++++++++
 tb/tb_qos_burst_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the QoS burst arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no owner, BUSY = owner holds grant)
//   id_width()  : width of a requester index, never less than one bit
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Combinational round-robin find-first.
// Scans vec starting at index ptr, wrapping at N, and reports the first set bit.
//   vec   : candidate vector
//   ptr   : scan start index (always < N)
//   found : at least one bit of vec is set
//   idx   : index of the first set bit at or after ptr (0 when nothing found)
module rr_find_first #(
  parameter int N   = 9,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] pos;

  // NOTE: every output and temporary gets a default at the top of the block, so
  // no path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDW'((int'(ptr) + i) % N);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/qos_burst_arbiter.sv
// Locking, QoS-aware round-robin burst arbiter for the shared memory channel.
// Requester 0 is the CPU, the others are GPU units. A grant is held for a
// whole burst and dropped on abort, on the last beat, or after MAX_BURST beats.
// Selection order: starved requesters, then high class, then low class.
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   req          : per-requester request, held for the whole burst
//   req_last     : per-requester "current beat is the last one"
//   ready        : downstream accepts the current beat
//   gnt          : registered one-hot grant
//   gnt_id       : index of the granted requester (holds after release)
//   gnt_valid    : grant present (equals |gnt)
//   starve_grant : current grant was won through the starved set
module qos_burst_arbiter
  import arb_pkg::*;
#(
  parameter int                 NUM_REQ      = 9,
  parameter logic [NUM_REQ-1:0] HI_MASK      = 9'h1FE,
  parameter int                 STARVE_LIMIT = 16,
  parameter int                 MAX_BURST    = 8,
  localparam int                IDW          = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid,
  output logic               starve_grant
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [AW-1:0]  AGE_MAX  = AW'(STARVE_LIMIT);
  localparam logic [BW-1:0]  BEAT_MAX = BW'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  arb_state_e     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] hi_ptr;
  logic [IDW-1:0] lo_ptr;
  logic [BW-1:0]  beat_cnt;
  logic [AW-1:0]  age [NUM_REQ];

  // ---------------------------------------------------------------------------
  // Candidate sets and per-set round-robin search
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] s_vec;
  logic [NUM_REQ-1:0] h_vec;
  logic [NUM_REQ-1:0] l_vec;

  always_comb begin
    s_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_vec[i] = req[i] && (age[i] >= AGE_MAX);
    end
  end

  assign h_vec = req & HI_MASK;
  assign l_vec = req & ~HI_MASK;

  logic           s_found, h_found, l_found;
  logic [IDW-1:0] s_idx, h_idx, l_idx;

  // Starved requesters share the low-class pointer.
  rr_find_first #(.N(NUM_REQ), .IDW(IDW)) u_ff_starve (
    .vec(s_vec), .ptr(lo_ptr), .found(s_found), .idx(s_idx)
  );
  rr_find_first #(.N(NUM_REQ), .IDW(IDW)) u_ff_hi (
    .vec(h_vec), .ptr(hi_ptr), .found(h_found), .idx(h_idx)
  );
  rr_find_first #(.N(NUM_REQ), .IDW(IDW)) u_ff_lo (
    .vec(l_vec), .ptr(lo_ptr), .found(l_found), .idx(l_idx)
  );

  logic [IDW-1:0] win_idx;
  logic           win_starved;
  logic [IDW-1:0] win_next_ptr;

  always_comb begin
    win_idx     = l_idx;
    win_starved = 1'b0;
    if (s_found) begin
      win_idx     = s_idx;
      win_starved = 1'b1;
    end else if (h_found) begin
      win_idx = h_idx;
    end
  end

  assign win_next_ptr = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Burst tracking for the current owner
  // ---------------------------------------------------------------------------
  logic          owner_req;
  logic          beat;
  logic [BW-1:0] beat_inc;
  logic          burst_done;

  assign owner_req  = req[owner];
  assign beat       = owner_req && ready;
  assign beat_inc   = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 1'b1;
  assign burst_done = req_last[owner] || (beat_inc == BEAT_MAX);

  // ---------------------------------------------------------------------------
  // FSM, pointers, ages and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      hi_ptr       <= '0;
      lo_ptr       <= '0;
      beat_cnt     <= '0;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      starve_grant <= 1'b0;
      // NOTE: the age array is real arbitration state, not a data buffer, so
      // it must be cleared by reset like any other register.
      for (int i = 0; i < NUM_REQ; i++) begin
        age[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state        <= BUSY;
            owner        <= win_idx;
            gnt          <= NUM_REQ'(1) << win_idx;
            gnt_valid    <= 1'b1;
            starve_grant <= win_starved;
            beat_cnt     <= '0;
            if (HI_MASK[win_idx]) hi_ptr <= win_next_ptr;
            else                  lo_ptr <= win_next_ptr;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (IDW'(i) == win_idx)   age[i] <= '0;
              else if (!req[i])         age[i] <= '0;
              else if (age[i] < AGE_MAX) age[i] <= age[i] + 1'b1;
            end
          end
        end

        BUSY: begin
          // Abort beats everything; otherwise only an accepted beat can end it.
          if (!owner_req || (beat && burst_done)) begin
            state        <= IDLE;
            gnt          <= '0;
            gnt_valid    <= 1'b0;
            starve_grant <= 1'b0;
            beat_cnt     <= '0;
          end else if (beat) begin
            beat_cnt <= beat_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_id = owner;

endmodule

// File: tb/tb_qos_burst_arbiter.sv
// Self-checking bench for qos_burst_arbiter (NUM_REQ=9, HI_MASK=9'h1FE,
// STARVE_LIMIT=4, MAX_BURST=4): directed vector tables, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_qos_burst_arbiter;

  localparam int         N     = 9;
  localparam logic [8:0] HI    = 9'h1FE;
  localparam int         SLIM  = 4;
  localparam int         MAXB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] req = '0;
  logic [8:0] req_last = '0;
  logic       ready = 1'b0;
  logic [8:0] gnt;
  logic [3:0] gnt_id;
  logic       gnt_valid;
  logic       starve_grant;

  int checks = 0;
  int failures = 0;

  qos_burst_arbiter #(
    .NUM_REQ(N), .HI_MASK(HI), .STARVE_LIMIT(SLIM), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .ready(ready),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .starve_grant(starve_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] req;
    logic [8:0] last;
    logic       rdy;
    logic [8:0] exp_gnt;
    logic [3:0] exp_id;
    logic       exp_starve;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pack(input logic [8:0] g, input logic [3:0] id,
                                       input logic v, input logic s);
    return {17'd0, s, v, id, g};
  endfunction

  function automatic logic [31:0] dut_out();
    return pack(gnt, gnt_id, gnt_valid, starve_grant);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {st,v,id,gnt}=%h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, return at
  // the next falling edge with outputs settled.
  task automatic step(input logic [8:0] r, input logic [8:0] l, input logic rd);
    req = r; req_last = l; ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req = 9'($urandom); req_last = 9'($urandom); ready = 1'($urandom);
    #1 check({name, "_async"}, dut_out(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check(name, dut_out(), 32'd0);
    req = '0; req_last = '0; ready = 1'b0; rst_n = 1'b1;
  endtask

  task automatic add(input logic [8:0] r, input logic [8:0] l, input logic rd,
                     input logic [8:0] g, input logic [3:0] id, input logic s);
    vec_t v;
    v.req = r; v.last = l; v.rdy = rd; v.exp_gnt = g; v.exp_id = id; v.exp_starve = s;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].last, tbl[i].rdy);
      check($sformatf("%s[%0d]", name, i), dut_out(),
            pack(tbl[i].exp_gnt, tbl[i].exp_id, tbl[i].exp_gnt != 0, tbl[i].exp_starve));
    end
    tbl.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: arbitration rules in plain integer arithmetic.
  // ---------------------------------------------------------------------------
  bit m_busy;
  int m_owner, m_id, m_hi, m_lo, m_beats;
  bit m_starve;
  int m_age[N];

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_id = 0; m_hi = 0; m_lo = 0; m_beats = 0; m_starve = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endfunction

  function automatic int pick(input logic [8:0] set, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (set[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [8:0] r, input logic [8:0] l, input logic rd);
    logic [8:0] starved;
    int w;
    bit fs;
    if (!m_busy) begin
      if (r != 0) begin
        starved = '0;
        for (int i = 0; i < N; i++) starved[i] = r[i] && (m_age[i] >= SLIM);
        fs = (starved != 0);
        if (fs)                w = pick(starved, m_lo);
        else if ((r & HI) != 0) w = pick(r & HI, m_hi);
        else                   w = pick(r & ~HI, m_lo);
        if (HI[w]) m_hi = (w + 1) % N;
        else       m_lo = (w + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (i == w)     m_age[i] = 0;
          else if (r[i])  m_age[i] = (m_age[i] + 1 > SLIM) ? SLIM : m_age[i] + 1;
          else            m_age[i] = 0;
        end
        m_busy = 1; m_owner = w; m_id = w; m_starve = fs; m_beats = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_starve = 0; m_beats = 0;
    end else if (rd) begin
      m_beats++;
      if (l[m_owner] || m_beats == MAXB) begin
        m_busy = 0; m_starve = 0; m_beats = 0;
      end
    end
  endfunction

  function automatic logic [31:0] model_out();
    return pack(m_busy ? 9'(1 << m_owner) : 9'd0, 4'(m_id), m_busy, m_busy && m_starve);
  endfunction

  // ---------------------------------------------------------------------------
  initial begin
    logic pat[6];
    logic [8:0] r, l;
    logic rd;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values with random inputs.
    do_reset("reset");

    // Single beat from the CPU, then one IDLE bubble, then regrant.
    add(9'h001, 9'h001, 1'b1, 9'h001, 4'd0, 1'b0);
    add(9'h001, 9'h001, 1'b1, 9'h000, 4'd0, 1'b0);
    add(9'h001, 9'h001, 1'b1, 9'h001, 4'd0, 1'b0);
    run_table("single");

    // Round-robin among high-class requesters 1, 3, 5.
    do_reset("reset_rr");
    add(9'h02A, 9'h1FF, 1'b1, 9'h002, 4'd1, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h000, 4'd1, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h008, 4'd3, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h000, 4'd3, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h020, 4'd5, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h000, 4'd5, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h002, 4'd1, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h000, 4'd1, 1'b0);
    add(9'h02A, 9'h1FF, 1'b1, 9'h008, 4'd3, 1'b0);
    run_table("rr");

    // Starvation: CPU loses four decisions to requester 2, then wins starved.
    do_reset("reset_starve");
    for (int k = 0; k < 4; k++) begin
      add(9'h005, 9'h1FF, 1'b1, 9'h004, 4'd2, 1'b0);
      add(9'h005, 9'h1FF, 1'b1, 9'h000, 4'd2, 1'b0);
    end
    add(9'h005, 9'h1FF, 1'b1, 9'h001, 4'd0, 1'b1);
    add(9'h005, 9'h1FF, 1'b1, 9'h000, 4'd0, 1'b0);
    add(9'h005, 9'h1FF, 1'b1, 9'h004, 4'd2, 1'b0);
    run_table("starve");

    // Forced release after MAX_BURST accepted beats with ready stalls.
    do_reset("reset_force");
    step(9'h010, 9'h000, 1'b1);
    check("force_grant", dut_out(), pack(9'h010, 4'd4, 1'b1, 1'b0));
    for (int k = 0; k < 6; k++) begin
      step(9'h010, 9'h000, pat[k]);
      check($sformatf("force_busy[%0d]", k), dut_out(),
            (k < 5) ? pack(9'h010, 4'd4, 1'b1, 1'b0) : pack(9'h000, 4'd4, 1'b0, 1'b0));
    end

    // Abort after two beats; the next burst counts from zero again.
    do_reset("reset_abort");
    step(9'h040, 9'h000, 1'b1);
    check("abort_grant", dut_out(), pack(9'h040, 4'd6, 1'b1, 1'b0));
    step(9'h040, 9'h000, 1'b1);
    step(9'h040, 9'h000, 1'b1);
    check("abort_two_beats", dut_out(), pack(9'h040, 4'd6, 1'b1, 1'b0));
    step(9'h000, 9'h000, 1'b1);
    check("abort_release", dut_out(), pack(9'h000, 4'd6, 1'b0, 1'b0));
    step(9'h040, 9'h000, 1'b1);
    check("abort_regrant", dut_out(), pack(9'h040, 4'd6, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++) begin
      step(9'h040, 9'h000, 1'b1);
      check($sformatf("abort_count[%0d]", k), dut_out(),
            (k < 3) ? pack(9'h040, 4'd6, 1'b1, 1'b0) : pack(9'h000, 4'd6, 1'b0, 1'b0));
    end
    step(9'h140, 9'h1FF, 1'b1);
    check("abort_next_arb", dut_out(), pack(9'h100, 4'd8, 1'b1, 1'b0));

    // Reset asserted mid-burst.
    do_reset("reset_mid_pre");
    step(9'h008, 9'h000, 1'b1);
    step(9'h008, 9'h000, 1'b1);
    check("mid_busy", dut_out(), pack(9'h008, 4'd3, 1'b1, 1'b0));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_reset_async", dut_out(), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_next", dut_out(), 32'd0);
    rst_n = 1'b1;
    step(9'h000, 9'h000, 1'b0);
    check("mid_reset_idle", dut_out(), 32'd0);

    // Randomized traffic against the reference model.
    do_reset("reset_rand");
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      r = 9'($urandom) & 9'($urandom);
      if (m_busy && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      l = 9'($urandom) & 9'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      model_step(r, l, rd);
      step(r, l, rd);
      check($sformatf("rand[%0d]", c), dut_out(), model_out());
      if (gnt_valid !== (|gnt) || ($countones(gnt) > 1)) begin
        check($sformatf("rand_onehot[%0d]", c), {23'd0, gnt_valid, gnt}, {22'd0, 1'b1, 9'h000});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
